// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port Memoria64 access controller.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        DWORD = 2'b00,
        WORD  = 2'b01,
        HALF  = 2'b10,
        BYTE  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam size_t FETCH_TAM = WORD;

endpackage

// File: rtl/mem_arbiter64_load_extend.sv
// Sign/zero extension of a sized load taken from the low bits of a memory dword.
module load_extend
    import mem_arb_pkg::*;
(
    input  logic [63:0] data_i,
    input  size_t       size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            WORD:    data_o = unsigned_i ? {32'd0, data_i[31:0]}
                                         : {{32{data_i[31]}}, data_i[31:0]};
            HALF:    data_o = unsigned_i ? {48'd0, data_i[15:0]}
                                         : {{48{data_i[15]}}, data_i[15:0]};
            BYTE:    data_o = unsigned_i ? {56'd0, data_i[7:0]}
                                         : {{56{data_i[7]}}, data_i[7:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter64.sv
// Round-robin controller sharing Memoria64 between the fetch port and the data port,
// sequencing registered reads and single-cycle writes.
module mem_arbiter64
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter bit RST_PRIO_D = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    output logic [ADDR_W-1:0] m_raddr,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [63:0]       m_wdata,
    output logic              m_wr,
    output logic [1:0]        m_tam,
    input  logic [63:0]       m_rdata
);

    state_t            state_q, state_d;
    port_t             ptr_q, ptr_d;
    port_t             win_q, win_d;
    size_t             size_q, size_d;
    size_t             tam_q, tam_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [31:0]       irdata_q, irdata_d;
    logic [63:0]       drdata_q, drdata_d;
    logic              grant_i, grant_d;
    logic              idle;
    logic              rd_i, rd_d;
    logic [63:0]       ext_data;

    load_extend u_load_extend (
        .data_i     (m_rdata),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    // ptr_q names the port that wins the next conflict.
    assign idle    = (state_q == IDLE) && Rst_n;
    assign grant_d = idle && d_req && (!i_req || ptr_q == PORT_D);
    assign grant_i = idle && i_req && (!d_req || ptr_q == PORT_I);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        size_d   = size_q;
        tam_d    = tam_q;
        uns_d    = uns_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    win_d  = PORT_D;
                    ptr_d  = PORT_I;
                    size_d = size_t'(d_size);
                    tam_d  = size_t'(d_size);
                    uns_d  = d_unsigned;
                    if (d_we) begin
                        waddr_d = d_addr;
                        wdata_d = d_wdata;
                        state_d = WR;
                    end else begin
                        raddr_d = d_addr;
                        state_d = RD_ADDR;
                    end
                end else if (grant_i) begin
                    win_d   = PORT_I;
                    ptr_d   = PORT_D;
                    size_d  = FETCH_TAM;
                    tam_d   = FETCH_TAM;
                    uns_d   = 1'b1;
                    raddr_d = i_addr;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                state_d = IDLE;
                if (win_q == PORT_I) irdata_d = m_rdata[31:0];
                else                 drdata_d = ext_data;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= port_t'(RST_PRIO_D);
            win_q    <= PORT_I;
            size_q   <= DWORD;
            tam_q    <= DWORD;
            uns_q    <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            size_q   <= size_d;
            tam_q    <= tam_d;
            uns_q    <= uns_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    // Read data is live from the memory in RD_DATA and held from the last read otherwise.
    assign rd_i     = (state_q == RD_DATA) && (win_q == PORT_I);
    assign rd_d     = (state_q == RD_DATA) && (win_q == PORT_D);
    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = rd_i;
    assign d_rvalid = rd_d;
    assign i_rdata  = rd_i ? m_rdata[31:0] : irdata_q;
    assign d_rdata  = rd_d ? ext_data : drdata_q;
    assign m_raddr  = raddr_q;
    assign m_waddr  = waddr_q;
    assign m_wdata  = wdata_q;
    assign m_wr     = (state_q == WR);
    assign m_tam    = tam_q;

endmodule

// File: tb/tb_mem_arbiter64.sv
// Scoreboard bench for mem_arbiter64 with a byte-addressed registered-read memory model.
module tb_mem_arbiter64;

    logic        Clk;
    logic        Rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic [63:0] m_raddr;
    logic [63:0] m_waddr;
    logic [63:0] m_wdata;
    logic        m_wr;
    logic [1:0]  m_tam;
    logic [63:0] m_rdata;

    mem_arbiter64 #(.ADDR_W(64), .RST_PRIO_D(1'b1)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .m_raddr    (m_raddr),
        .m_waddr    (m_waddr),
        .m_wdata    (m_wdata),
        .m_wr       (m_wr),
        .m_tam      (m_tam),
        .m_rdata    (m_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Memory model: little-endian bytes, registered read, tam-sized write.
    logic [7:0]  mem [0:65535];
    logic [63:0] rd_q;
    bit          loaded = 1'b0;
    assign m_rdata = rd_q;

    always @(posedge Clk) begin
        if (!loaded) begin
            for (int k = 0; k < 65536; k++) mem[k] <= 8'h00;
            mem[16'h0010] <= 8'h80;
            mem[16'h002F] <= 8'h5A;
            for (int k = 0; k < 8; k++) mem[16'h0030 + 16'(k)] <= 8'hFF;
            for (int k = 0; k < 8; k++) mem[16'h0050 + 16'(k)] <= 8'h77;
            mem[16'h0040] <= 8'hEF; mem[16'h0041] <= 8'hBE;
            mem[16'h0042] <= 8'hAD; mem[16'h0043] <= 8'hDE;
            mem[16'h0048] <= 8'hEF; mem[16'h0049] <= 8'hCD;
            mem[16'h004A] <= 8'hAB; mem[16'h004B] <= 8'h89;
            mem[16'h004C] <= 8'h67; mem[16'h004D] <= 8'h45;
            mem[16'h004E] <= 8'h23; mem[16'h004F] <= 8'h01;
            rd_q   <= 64'd0;
            loaded <= 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) rd_q[8*k +: 8] <= mem[m_raddr[15:0] + 16'(k)];
            if (m_wr) begin
                for (int k = 0; k < (8 >> m_tam); k++)
                    mem[m_waddr[15:0] + 16'(k)] <= m_wdata[8*k +: 8];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    // Monitor: pops expectations whenever an rvalid appears.
    always @(negedge Clk) begin
        exp_t e;
        if (i_rvalid && d_rvalid) bad("both_rvalid");
        if (d_rvalid) begin
            if (dq.size() == 0) bad("d_rvalid_unexpected");
            else begin
                e = dq.pop_front();
                chk("d_rdata", d_rdata, e.data);
                chk("d_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (i_rvalid) begin
            if (iq.size() == 0) bad("i_rvalid_unexpected");
            else begin
                e = iq.pop_front();
                chk("i_rdata", {32'd0, i_rdata}, e.data);
                chk("i_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_gnt"},    {62'd0, i_gnt, d_gnt}, 64'd0);
        chk({tag, "_rvalid"}, {62'd0, i_rvalid, d_rvalid}, 64'd0);
        chk({tag, "_m_wr"},   {63'd0, m_wr}, 64'd0);
        chk({tag, "_m_raddr"}, m_raddr, 64'd0);
        chk({tag, "_m_waddr"}, m_waddr, 64'd0);
        chk({tag, "_m_wdata"}, m_wdata, 64'd0);
        chk({tag, "_m_tam"},  {62'd0, m_tam}, 64'd0);
        chk({tag, "_i_rdata"}, {32'd0, i_rdata}, 64'd0);
        chk({tag, "_d_rdata"}, d_rdata, 64'd0);
    endtask

    task automatic wait_dgnt(output bit ok);
        int k = 0;
        while (!d_gnt && k < 20) begin
            @(negedge Clk); #1;
            k++;
        end
        ok = d_gnt;
        if (!ok) bad("d_gnt_timeout");
    endtask

    task automatic do_load(input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] exp);
        bit ok;
        d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_size = size; d_unsigned = uns;
        #1;
        wait_dgnt(ok);
        if (ok) dq.push_back('{exp, cyc + 2});
        @(posedge Clk); #1;
        d_req = 1'b0;
    endtask

    task automatic do_store(input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] data);
        bit ok;
        d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_size = size; d_wdata = data;
        #1;
        wait_dgnt(ok);
        @(posedge Clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        chk("st_m_wr_on", {63'd0, m_wr}, 64'd1);
        chk("st_m_tam", {62'd0, m_tam}, {62'd0, size});
        chk("st_m_waddr", m_waddr, addr);
        chk("st_m_wdata", m_wdata, data);
        @(posedge Clk); #1;
        chk("st_m_wr_off", {63'd0, m_wr}, 64'd0);
    endtask

    initial begin
        bit ok;
        int n;
        Rst_n = 1'b0;
        i_req = 1'b1; i_addr = 64'h40;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
        d_addr = 64'h48; d_wdata = 64'd0;
        repeat (3) @(negedge Clk);
        #1;
        check_reset_outs("rst0");

        // Both ports requesting out of reset: grants alternate starting with data.
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (i_gnt || d_gnt) begin
                chk("rr_one_gnt", {63'd0, i_gnt && d_gnt}, 64'd0);
                chk("rr_order", {63'd0, d_gnt}, (n % 2 == 0) ? 64'd1 : 64'd0);
                if (d_gnt) dq.push_back('{64'h0123_4567_89AB_CDEF, cyc + 2});
                else       iq.push_back('{64'h0000_0000_DEAD_BEEF, cyc + 2});
                n++;
                if (n == 4) begin
                    @(posedge Clk); #1;
                    i_req = 1'b0; d_req = 1'b0;
                end
            end
            @(negedge Clk); #1;
        end
        if (n < 4) bad("rr_timeout");
        repeat (3) @(negedge Clk);
        #1;

        do_load(64'h10, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(64'h10, 2'b11, 1'b1, 64'h0000_0000_0000_0080);
        do_store(64'h20, 2'b00, 64'h1122_3344_5566_7788);
        do_load(64'h20, 2'b01, 1'b0, 64'h0000_0000_5566_7788);
        do_store(64'h30, 2'b10, 64'h0000_0000_0000_BEEF);
        do_load(64'h30, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF);
        do_load(64'h30, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF);
        do_load(64'h30, 2'b10, 1'b1, 64'h0000_0000_0000_BEEF);
        do_load(64'h40, 2'b01, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);
        do_load(64'h40, 2'b01, 1'b1, 64'h0000_0000_DEAD_BEEF);
        repeat (3) @(negedge Clk);
        chk("half_store_neighbour", {56'd0, mem[16'h002F]}, 64'h5A);

        // Reset while the read is in RD_ADDR: access aborted, outputs cleared at once.
        @(negedge Clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48; d_size = 2'b00; d_unsigned = 1'b0;
        #1;
        wait_dgnt(ok);
        @(posedge Clk); #1;
        d_req = 1'b0;
        chk("abort_rd_raddr", m_raddr, 64'h48);
        Rst_n = 1'b0;
        #1;
        check_reset_outs("rst_rd");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        #1;

        // Reset while in WR: the store is dropped.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h50; d_size = 2'b00;
        d_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
        #1;
        wait_dgnt(ok);
        @(posedge Clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        chk("abort_wr_m_wr", {63'd0, m_wr}, 64'd1);
        Rst_n = 1'b0;
        #1;
        check_reset_outs("rst_wr");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        i_req = 1'b1; i_addr = 64'h40;
        #1;
        chk("post_rst_i_gnt", {63'd0, i_gnt}, 64'd1);
        if (i_gnt) iq.push_back('{64'h0000_0000_DEAD_BEEF, cyc + 2});
        @(posedge Clk); #1;
        i_req = 1'b0;
        chk("fetch_m_tam", {62'd0, m_tam}, 64'd1);
        chk("fetch_m_wr", {63'd0, m_wr}, 64'd0);
        repeat (4) @(negedge Clk);
        chk("dropped_store_lo", {56'd0, mem[16'h0050]}, 64'h77);
        chk("dropped_store_hi", {56'd0, mem[16'h0057]}, 64'h77);
        chk("scoreboard_empty", 64'(iq.size() + dq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
